// File: rtl/sim_dump_pkg.sv
// Shared types and constants for the run/trace/dump controller.
package sim_dump_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_REG   = 3'd1,
    ST_MEM_A = 3'd2,
    ST_MEM_D = 3'd3,
    ST_END   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] KIND_PC  = 2'b00;
  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_MEM = 2'b10;
  localparam logic [1:0] KIND_END = 2'b11;

  localparam logic CAUSE_HALT    = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;

endpackage

// File: rtl/sim_dump_ctrl_dump_counter.sv
// Index counter 0..N-1 with terminal-count flag; wraps to 0 after the last index.
module dump_counter #(
  parameter int unsigned N = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  inc_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  cnt_o,
  output logic                                  tc_o
);
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tc_o  = (cnt_q == W'(N - 1));
    cnt_d = cnt_q;
    if (inc_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sim_dump_ctrl.sv
// Run/trace/dump controller: traces PCs, detects end of run, then streams
// register file, a memory window and an end marker over a valid/ready port.
module sim_dump_ctrl
  import sim_dump_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 32,
  parameter logic [31:0] MEM_BASE   = 32'h4000,
  parameter int unsigned MEM_WORDS  = 4,
  parameter int unsigned MAX_CYCLES = 64,
  parameter logic [31:0] HALT_INST  = 32'h0000_0000,
  parameter bit          TRACE_PC   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          pc,
  input  logic [31:0]                inst,
  output logic [$clog2(NREGS)-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic [31:0]                mem_raddr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       stall,
  output logic                       halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [DATA_W-1:0]          out_data,
  output logic                       done
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam int unsigned NM = (MEM_WORDS > 0) ? MEM_WORDS : 1;
  localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          cause_q, cause_d;
  logic          reg_inc, mem_inc, reg_tc, mem_tc, adv;
  logic [RW-1:0] reg_idx;
  logic [MW-1:0] mem_idx;

  dump_counter #(.N(NREGS)) u_reg_cnt (
    .clk(clk), .reset(reset), .inc_i(reg_inc), .cnt_o(reg_idx), .tc_o(reg_tc)
  );

  dump_counter #(.N(NM)) u_mem_cnt (
    .clk(clk), .reset(reset), .inc_i(mem_inc), .cnt_o(mem_idx), .tc_o(mem_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cyc_q   <= '0;
      cause_q <= CAUSE_HALT;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cause_d   = cause_q;
    out_valid = 1'b0;
    out_kind  = KIND_PC;
    out_data  = '0;
    stall     = 1'b0;
    halt      = 1'b1;
    done      = 1'b0;
    rf_raddr  = '0;
    mem_raddr = '0;
    reg_inc   = 1'b0;
    mem_inc   = 1'b0;
    adv       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        halt = 1'b0;
        if (TRACE_PC) begin
          out_valid = 1'b1;
          out_data  = pc;
          stall     = !out_ready;
        end
        adv = !stall;
        if (adv) begin
          if (cyc_q != CW'(MAX_CYCLES)) cyc_d = cyc_q + CW'(1);
          // Halt takes priority when it lands on the final budgeted cycle.
          if (inst == HALT_INST) begin
            cause_d = CAUSE_HALT;
            state_d = ST_REG;
          end else if (cyc_q == CW'(MAX_CYCLES - 1)) begin
            cause_d = CAUSE_TIMEOUT;
            state_d = ST_REG;
          end
        end
      end
      ST_REG: begin
        out_valid = 1'b1;
        out_kind  = KIND_REG;
        out_data  = rf_rdata;
        rf_raddr  = reg_idx;
        if (out_ready) begin
          reg_inc = 1'b1;
          if (reg_tc) state_d = (MEM_WORDS == 0) ? ST_END : ST_MEM_A;
        end
      end
      ST_MEM_A: begin
        mem_raddr = MEM_BASE + 32'(mem_idx);
        state_d   = ST_MEM_D;
      end
      ST_MEM_D: begin
        // Address is held so the synchronous read stays stable under backpressure.
        mem_raddr = MEM_BASE + 32'(mem_idx);
        out_valid = 1'b1;
        out_kind  = KIND_MEM;
        out_data  = mem_rdata;
        if (out_ready) begin
          mem_inc = 1'b1;
          state_d = mem_tc ? ST_END : ST_MEM_A;
        end
      end
      ST_END: begin
        out_valid = 1'b1;
        out_kind  = KIND_END;
        out_data  = {cause_q, (DATA_W-1)'(cyc_q)};
        if (out_ready) state_d = ST_DONE;
      end
      ST_DONE: done = 1'b1;
      default: state_d = ST_RUN;
    endcase

    if (reset) begin
      out_valid = 1'b0;
      out_kind  = KIND_PC;
      out_data  = '0;
      stall     = 1'b0;
      halt      = 1'b0;
      done      = 1'b0;
      rf_raddr  = '0;
      mem_raddr = '0;
      reg_inc   = 1'b0;
      mem_inc   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sim_dump_ctrl.sv
// Scoreboard bench for sim_dump_ctrl: default instance plus a small no-trace/no-memory instance.
module tb_sim_dump_ctrl;

  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] NO_HLT = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b1;
  logic [31:0] halt_pc = NO_HLT;
  bit          sel = 1'b0;

  logic [31:0] a_pc, a_inst, a_rf_rdata, a_mem_raddr, a_mem_rdata, a_data;
  logic [4:0]  a_rf_raddr;
  logic        a_stall, a_halt, a_valid, a_done;
  logic [1:0]  a_kind;

  logic [31:0] b_pc, b_inst, b_rf_rdata, b_mem_raddr, b_mem_rdata, b_data;
  logic [2:0]  b_rf_raddr;
  logic        b_stall, b_halt, b_valid, b_done;
  logic [1:0]  b_kind;

  int n_assert = 0;
  int n_fail   = 0;
  int pcs_seen = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  sim_dump_ctrl u_a (
    .clk(clk), .reset(reset), .pc(a_pc), .inst(a_inst),
    .rf_raddr(a_rf_raddr), .rf_rdata(a_rf_rdata),
    .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
    .stall(a_stall), .halt(a_halt), .out_valid(a_valid), .out_ready(out_ready),
    .out_kind(a_kind), .out_data(a_data), .done(a_done)
  );

  sim_dump_ctrl #(.NREGS(8), .MEM_WORDS(0), .TRACE_PC(1'b0)) u_b (
    .clk(clk), .reset(reset), .pc(b_pc), .inst(b_inst),
    .rf_raddr(b_rf_raddr), .rf_rdata(b_rf_rdata),
    .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
    .stall(b_stall), .halt(b_halt), .out_valid(b_valid), .out_ready(out_ready),
    .out_kind(b_kind), .out_data(b_data), .done(b_done)
  );

  function automatic logic [31:0] rf_val(input int unsigned i);
    if (i == 10) return 32'd42;
    if (i == 11) return 32'hCAFE_BABE;
    return 32'h1000_0000 + 32'(i * 16);
  endfunction

  // Core, register file and data memory models
  always_ff @(posedge clk) begin
    if (reset) begin
      a_pc <= '0;
      b_pc <= '0;
    end else begin
      if (!a_stall && !a_halt) a_pc <= a_pc + 32'd4;
      if (!b_stall && !b_halt) b_pc <= b_pc + 32'd4;
    end
    a_mem_rdata <= a_mem_raddr ^ KEY;
    b_mem_rdata <= b_mem_raddr ^ KEY;
  end

  assign a_inst     = (a_pc == halt_pc) ? 32'h0 : 32'h0000_0013;
  assign b_inst     = (b_pc == halt_pc) ? 32'h0 : 32'h0000_0013;
  assign a_rf_rdata = rf_val(32'(a_rf_raddr));
  assign b_rf_rdata = rf_val(32'(b_rf_raddr));

  logic        v_valid, v_stall, v_halt, v_done;
  logic [1:0]  v_kind;
  logic [31:0] v_data, v_mem_raddr;
  logic [4:0]  v_rf_raddr;

  assign v_valid     = sel ? b_valid : a_valid;
  assign v_stall     = sel ? b_stall : a_stall;
  assign v_halt      = sel ? b_halt  : a_halt;
  assign v_done      = sel ? b_done  : a_done;
  assign v_kind      = sel ? b_kind  : a_kind;
  assign v_data      = sel ? b_data  : a_data;
  assign v_mem_raddr = sel ? b_mem_raddr : a_mem_raddr;
  assign v_rf_raddr  = sel ? {2'b00, b_rf_raddr} : a_rf_raddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_check();
    chk("rst_valid", v_valid, 0);
    chk("rst_stall", v_stall, 0);
    chk("rst_halt", v_halt, 0);
    chk("rst_done", v_done, 0);
    chk("rst_rf_raddr", v_rf_raddr, 0);
    chk("rst_mem_raddr", v_mem_raddr, 0);
    chk("rst_kind", v_kind, 0);
    chk("rst_data", v_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_check();
    reset = 1'b0;
  endtask

  task automatic expect_run(input int n_pc, input int nregs, input int nmem, input logic [31:0] endd);
    sb.delete();
    for (int i = 0; i < n_pc; i++) sb.push_back({2'b00, 32'(i * 4)});
    for (int i = 0; i < nregs; i++) sb.push_back({2'b01, rf_val(32'(i))});
    for (int i = 0; i < nmem; i++) sb.push_back({2'b10, (32'h4000 + 32'(i)) ^ KEY});
    sb.push_back({2'b11, endd});
  endtask

  // Drives out_ready each cycle and checks every transfer against the scoreboard
  task automatic run_scn(input int n_pc, input bit rnd, input int stop_after);
    int          got = 0;
    bit          hold = 1'b0;
    bit          fin = 1'b0;
    logic [33:0] prev = '0;
    logic [33:0] exp;
    pcs_seen = 0;
    for (int c = 0; c < 800 && !fin; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("stall", v_stall, (!sel && pcs_seen < n_pc && !out_ready) ? 1 : 0);
      if (hold) begin
        chk("hold_valid", v_valid, 1);
        chk("hold_payload", {v_kind, v_data}, prev);
      end
      hold = v_valid && !out_ready;
      prev = {v_kind, v_data};
      if (v_valid && out_ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 34'h3_DEAD_BEEF;
        chk("record", {v_kind, v_data}, exp);
        if (v_kind == 2'b00) pcs_seen++;
        got++;
        if (got == stop_after) fin = 1'b1;
      end
      if (v_done) fin = 1'b1;
      @(negedge clk);
    end
    chk("scn_finished", fin, 1);
  endtask

  task automatic full_scn(input int n_pc, input bit rnd);
    run_scn(n_pc, rnd, -1);
    out_ready = 1'b1;
    #1;
    chk("queue_drained", 64'(sb.size()), 0);
    chk("done_held", v_done, 1);
    chk("halt_at_done", v_halt, 1);
    chk("no_valid_done", v_valid, 0);
  endtask

  initial begin
    // Halt at fourth instruction, free-flowing sink
    sel = 1'b0;
    halt_pc = 32'h0000_000C;
    do_reset();
    expect_run(4, 32, 4, 32'h0000_0004);
    full_scn(4, 1'b0);

    // Cycle budget expires
    halt_pc = NO_HLT;
    do_reset();
    expect_run(64, 32, 4, 32'h8000_0040);
    full_scn(64, 1'b0);

    // Halt on the last budgeted cycle: halt cause wins
    halt_pc = 32'h0000_00FC;
    do_reset();
    expect_run(64, 32, 4, 32'h0000_0040);
    full_scn(64, 1'b0);

    // Random backpressure, same record stream as the first run
    halt_pc = 32'h0000_000C;
    do_reset();
    expect_run(4, 32, 4, 32'h0000_0004);
    full_scn(4, 1'b1);

    // Reset in the middle of the register dump, then full rerun
    do_reset();
    expect_run(4, 32, 4, 32'h0000_0004);
    run_scn(4, 1'b0, 14);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset_check();
    reset = 1'b0;
    expect_run(4, 32, 4, 32'h0000_0004);
    full_scn(4, 1'b0);

    // No trace, no memory window, eight registers
    sel = 1'b1;
    do_reset();
    expect_run(0, 8, 0, 32'h0000_0004);
    full_scn(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_dump_ctrl.md
# sim_dump_ctrl

Parametrised run/trace/dump controller for the single-cycle datapath harness. Sits beside `machine`, streams one PC record per executed cycle, and detects end of run (halt instruction or cycle budget). It then freezes the core and serially dumps the register file and a configurable data-memory window over a valid/ready record stream. It adds backpressure, a timeout-vs-halt cause, and an end marker, and is generalised in register count, memory window and width.

## Interface
- `DATA_W`, 32, width of PC/register/memory words
- `NREGS`, 32, registers dumped (indices 0..NREGS-1)
- `MEM_BASE`, 32'h4000, first memory word index dumped
- `MEM_WORDS`, 4, memory words dumped; 0 skips the memory phase
- `MAX_CYCLES`, 64, cycle budget, ≥1
- `HALT_INST`, 32'h00000000, instruction encoding that ends the run
- `TRACE_PC`, 1, 0 suppresses PC records (core never stalled)
- `clk` in 1 — the single clock
- `reset` in 1 — synchronous, active-high
- `pc` in DATA_W — current PC (byte address)
- `inst` in 32 — instruction at `pc`
- `rf_raddr` out $clog2(NREGS) — register-file read index; `rf_rdata` returns combinationally
- `rf_rdata` in DATA_W
- `mem_raddr` out 32 — data-memory word index; synchronous read, `mem_rdata` is valid the cycle after
- `mem_rdata` in DATA_W
- `stall` out 1 — core must not advance this cycle
- `halt` out 1 — core frozen (run over)
- `out_valid` out 1, `out_ready` in 1 — record handshake
- `out_kind` out 2 — 00 PC, 01 REG, 10 MEM, 11 END
- `out_data` out DATA_W — record payload
- `done` out 1 — dump complete, held until reset

## Operation
- States: RUN → REG → MEM_A → MEM_D → END → DONE. Reset enters RUN.
- RUN:
  - Each cycle is an *advance* when `stall`=0.
  - If TRACE_PC, emit {00, pc}. `stall` = TRACE_PC & !out_ready.
  - The cycle counter `cyc` increments on every advance.
  - On an advance with `inst`==HALT_INST, cause=HALT. Otherwise, on the advance where `cyc`+1==MAX_CYCLES, cause=TIMEOUT. HALT wins when both occur together.
  - Either cause moves the FSM to REG. The PC record of the ending cycle is emitted.
- REG:
  - idx 0..NREGS-1, `rf_raddr`=idx, emit {01, rf_rdata}.
  - idx advances on transfer. After the last register, go to MEM_A, or to END if MEM_WORDS=0.
- MEM_A: drive `mem_raddr`=MEM_BASE+idx for one cycle, with no record.
- MEM_D:
  - Keep `mem_raddr` stable and emit {10, mem_rdata}.
  - On transfer, increment idx and return to MEM_A, or go to END after MEM_WORDS words.
- END:
  - Emit {11, data}: data[DATA_W-1] = cause (1=TIMEOUT), low bits = `cyc` (cycles executed).
  - On transfer, go to DONE.
- DONE: no records; `done`=1.
- `halt`=1 in every state except RUN.
- Width rules: `cyc` is $clog2(MAX_CYCLES+1) bits and never wraps. `mem_raddr` is 32-bit modulo.

## Timing
- Reset values: `out_valid`=0, `stall`=0, `halt`=0, `done`=0, `rf_raddr`=0, `mem_raddr`=0, `out_kind`=00, `out_data`=0, `cyc`=0, idx=0.
- While reset is high, every output is forced to its reset value, including mid-dump. The next cycle restarts in RUN.
- Handshake:
  - Transfer occurs when `out_valid` & `out_ready` are both high.
  - While `out_valid`=1 and `out_ready`=0, `out_kind`/`out_data` stay stable; the memory data stays stable because `mem_raddr` is held.
  - `out_valid` never drops without a transfer, except on reset.
- Latency:
  - PC record: same cycle as `pc`.
  - First REG record: the cycle after the ending advance.
  - Each MEM word costs ≥2 cycles.
  - Minimum dump length: NREGS + 2·MEM_WORDS + 1 cycles with `out_ready` held at 1.

## Structure
- Shared package `sim_dump_pkg`:
  - State enum.
  - Record-kind constants KIND_PC/REG/MEM/END.
  - Cause bit values.
- One sub-module, `dump_counter`: parametrised index counter with terminal-count flag, used for both the register and memory phases.

## Test plan
- Halt at the 4th instruction (`inst`=0 at pc 0xC), `out_ready`=1 → PC records 0x0, 0x4, 0x8, 0xC; then 32 REG records with r10=42 and r11=0xCAFEBABE; then 4 MEM records for words 0x4000–0x4003; then END data 0x00000004; then `done`=1.
- No halt, MAX_CYCLES=64 → exactly 64 PC records, END data = 0x80000040.
- Halt instruction on cycle 64 (both causes together) → END cause bit 0, count 64.
- `out_ready` toggled randomly 50% → `stall` high exactly on RUN cycles where `out_ready`=0; payload stable under backpressure; record sequence identical to the first scenario.
- MEM_WORDS=0, TRACE_PC=0, NREGS=8 → 8 REG records, then END, with no MEM records and `stall` never asserted.
- Reset asserted during the REG phase → all outputs return to reset values the next cycle; the run then repeats identically from RUN.
